sd_ctrl_regs: RTL and testbench
===============================

SD_CTRL_REGS -- requirements
Module: sd_ctrl_regs

Interface
REQ-001 Parameter: DEPTH, 16, entries per buffer (power of two, >= 2).
REQ-002 Parameter: CW, $clog2(DEPTH)+1, occupancy count width.
REQ-003 pclk  in  1  sole clock; all state updates on rising edge.
REQ-004 preset  in  1  reset, asynchronous, active-low.
REQ-005 data_i  in  16  write data from APB controller.
REQ-006 st_buf_enq / addr_reg_ld / ctrl_reg_ld / ld_buf_deq  in  1 each  one-cycle strobes from APB controller.
REQ-007 ld_buf_data_o  out  16  LD buffer head word.
REQ-008 status_reg_data_o  out  16  status word (layout REQ-021).
REQ-009 st_deq_i  in  1  engine pops ST buffer; st_data_o  out  16  ST head; st_empty_o  out  1.
REQ-010 ld_enq_i  in  1  engine pushes LD buffer; ld_data_i  in  16; ld_full_o  out  1.
REQ-011 cmd_start_o  out  1  one-cycle command launch; cmd_o  out  8  command index; addr_o  out  16  command address.
REQ-012 eng_done_i  in  1  one-cycle completion pulse; eng_err_i  in  1  error, sampled with eng_done_i.

Function
REQ-013 ST and LD buffers: DEPTH-entry show-ahead FIFOs; head word on data output combinationally, valid whenever not empty.
REQ-014 Enqueue when full: write dropped, pointers unchanged, sticky OVF set.
REQ-015 Dequeue when empty: pointers unchanged, sticky UNF set; ld_buf_data_o reads 16'h0000 while LD empty.
REQ-016 Simultaneous enq+deq, non-empty and non-full: both occur, count unchanged; when full: both occur; when empty: enqueue only, no UNF.
REQ-017 Pointers: log2(DEPTH) bits, wrap modulo DEPTH; count saturates nowhere (REQ-014/015 prevent it).
REQ-018 addr_reg_ld: addr_o <= data_i next edge, any FSM state.
REQ-019 ctrl_reg_ld fields: [7:0] cmd index, [13] LD flush, [14] ST flush, [15] start.
REQ-020 Flush bits empty the named buffer in one cycle (pointers, count to 0); flush wins over same-cycle enq/deq of that buffer.
REQ-021 Status: [0] busy (FSM != IDLE), [1] DONE sticky, [2] ERR sticky, [3] st_full, [4] st_empty, [5] ld_full, [6] ld_empty, [7] OVF, [8] UNF, [13:9] LD count (zero-extended/truncated to 5 bits), [15:14] 0.
REQ-022 FSM states: IDLE, ISSUE, WAIT.
REQ-023 IDLE: ctrl_reg_ld with [15]=1 -> latch cmd_o, clear DONE/ERR/OVF/UNF, go ISSUE.
REQ-024 ISSUE: cmd_start_o=1 for exactly this cycle; unconditionally -> WAIT.
REQ-025 WAIT: eng_done_i -> set DONE, ERR<=eng_err_i, -> IDLE; otherwise stay.
REQ-026 Start in ISSUE/WAIT: ignored (cmd_o unchanged, no pulse); flush bits in same write still act.
REQ-027 eng_done_i outside WAIT: ignored.
REQ-028 Command issue latency: cmd_start_o asserted one cycle after the ctrl_reg_ld edge.

Reset
REQ-029 preset low: FSM IDLE, both FIFOs empty, addr_o/cmd_o 0, cmd_start_o 0, all stickies 0, status_reg_data_o = 16'h0050.
REQ-030 Reset mid-command (ISSUE/WAIT): immediate return to IDLE; buffered data discarded; storage array need not be cleared.

Structure
REQ-031 Shared package sd_pkg: FSM state enum, ctrl field bit positions, status bit positions.
REQ-032 Sub-module sd_fifo (DEPTH, WIDTH=16) instantiated twice, exposing full/empty/count/head/flush.

Verification
REQ-033 After reset -> status 16'h0050, cmd_start_o 0, ld_buf_data_o 16'h0000.
REQ-034 16 st_buf_enq of 0x1000..0x100F, 17th 0xBEEF -> st_full, OVF set, st_data_o pops 0x1000..0x100F in order, no 0xBEEF.
REQ-035 ld_buf_deq on empty -> UNF set, count 0; push 3 words, simultaneous enq+deq -> count stays 3, FIFO order preserved.
REQ-036 addr_reg_ld 0x0200, ctrl_reg_ld 0x8011 -> next cycle cmd_start_o=1, cmd_o 0x11, addr_o 0x0200, busy; second start 0x8022 in WAIT ignored; eng_done_i+eng_err_i -> status DONE|ERR, busy 0.
REQ-037 Fill both buffers to 5, ctrl_reg_ld 0x6000 -> both empty next cycle; preset pulse during WAIT -> IDLE, status 16'h0050.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared definitions for the SD controller register block:
// FSM encodings, control/status bit positions and the FIFO event record.
package sd_pkg;
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_ISSUE = 2'd1;
  localparam state_t S_WAIT  = 2'd2;

  localparam int CTRL_CMD_W    = 8;
  localparam int CTRL_LD_FLUSH = 13;
  localparam int CTRL_ST_FLUSH = 14;
  localparam int CTRL_START    = 15;

  localparam int STS_BUSY     = 0;
  localparam int STS_DONE     = 1;
  localparam int STS_ERR      = 2;
  localparam int STS_ST_FULL  = 3;
  localparam int STS_ST_EMPTY = 4;
  localparam int STS_LD_FULL  = 5;
  localparam int STS_LD_EMPTY = 6;
  localparam int STS_OVF      = 7;
  localparam int STS_UNF      = 8;
  localparam int STS_LDCNT_LO = 9;
  localparam int STS_LDCNT_W  = 5;

  typedef struct packed {
    logic ovf;
    logic unf;
  } fifo_evt_t;
endpackage

// File: rtl/sd_fifo.sv
// Show-ahead FIFO with single-cycle flush; reports rejected pushes and pops
// as one-cycle events so the parent can keep sticky flags.
module sd_fifo
  import sd_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enq,
  input  logic             deq,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head,
  output fifo_evt_t        evt
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_enq, do_deq;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign head   = mem[rd_ptr];
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_enq = enq & (~full | deq);
  assign do_deq = deq & ~empty;

  always_comb begin
    evt     = '0;
    evt.ovf = ~flush & enq & full & ~deq;
    evt.unf = ~flush & deq & empty & ~enq;
  end

  always_ff @(posedge clk) begin
    if (do_enq & ~flush) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + 1'b1;
      if (do_deq) rd_ptr <= rd_ptr + 1'b1;
      case ({do_enq, do_deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/sd_ctrl_regs.sv
// APB-facing register block of the SD controller: ST/LD data buffers,
// address/control registers, status word and the command issue FSM.
module sd_ctrl_regs
  import sd_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic [15:0] data_i,
  input  logic        st_buf_enq,
  input  logic        addr_reg_ld,
  input  logic        ctrl_reg_ld,
  input  logic        ld_buf_deq,
  output logic [15:0] ld_buf_data_o,
  output logic [15:0] status_reg_data_o,
  input  logic        st_deq_i,
  output logic [15:0] st_data_o,
  output logic        st_empty_o,
  input  logic        ld_enq_i,
  input  logic [15:0] ld_data_i,
  output logic        ld_full_o,
  output logic        cmd_start_o,
  output logic [7:0]  cmd_o,
  output logic [15:0] addr_o,
  input  logic        eng_done_i,
  input  logic        eng_err_i
);
  state_t          state;
  logic            done_r, err_r, ovf_r, unf_r;
  logic            st_full, st_empty, ld_full, ld_empty;
  logic [CW-1:0]   st_count, ld_count;
  logic [15:0]     ld_head;
  fifo_evt_t       st_evt, ld_evt;
  logic            start_acc, st_flush, ld_flush;
  logic            unused_st_count;

  assign st_flush  = ctrl_reg_ld & data_i[CTRL_ST_FLUSH];
  assign ld_flush  = ctrl_reg_ld & data_i[CTRL_LD_FLUSH];
  assign start_acc = ctrl_reg_ld & data_i[CTRL_START] & (state == S_IDLE);
  assign unused_st_count = ^st_count;

  sd_fifo #(.DEPTH(DEPTH), .WIDTH(16), .CW(CW)) u_st_fifo (
    .clk(pclk), .rst_n(preset),
    .enq(st_buf_enq), .deq(st_deq_i), .flush(st_flush), .wdata(data_i),
    .full(st_full), .empty(st_empty), .count(st_count), .head(st_data_o),
    .evt(st_evt)
  );

  sd_fifo #(.DEPTH(DEPTH), .WIDTH(16), .CW(CW)) u_ld_fifo (
    .clk(pclk), .rst_n(preset),
    .enq(ld_enq_i), .deq(ld_buf_deq), .flush(ld_flush), .wdata(ld_data_i),
    .full(ld_full), .empty(ld_empty), .count(ld_count), .head(ld_head),
    .evt(ld_evt)
  );

  assign st_empty_o    = st_empty;
  assign ld_full_o     = ld_full;
  assign ld_buf_data_o = ld_empty ? 16'h0000 : ld_head;
  assign cmd_start_o   = (state == S_ISSUE);

  always_comb begin
    status_reg_data_o = '0;
    status_reg_data_o[STS_BUSY]     = (state != S_IDLE);
    status_reg_data_o[STS_DONE]     = done_r;
    status_reg_data_o[STS_ERR]      = err_r;
    status_reg_data_o[STS_ST_FULL]  = st_full;
    status_reg_data_o[STS_ST_EMPTY] = st_empty;
    status_reg_data_o[STS_LD_FULL]  = ld_full;
    status_reg_data_o[STS_LD_EMPTY] = ld_empty;
    status_reg_data_o[STS_OVF]      = ovf_r;
    status_reg_data_o[STS_UNF]      = unf_r;
    status_reg_data_o[STS_LDCNT_LO +: STS_LDCNT_W] = STS_LDCNT_W'(ld_count);
  end

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      state  <= S_IDLE;
      cmd_o  <= '0;
      addr_o <= '0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
      ovf_r  <= 1'b0;
      unf_r  <= 1'b0;
    end else begin
      if (addr_reg_ld) addr_o <= data_i;
      case (state)
        S_IDLE:  if (start_acc) begin
                   cmd_o <= data_i[CTRL_CMD_W-1:0];
                   state <= S_ISSUE;
                 end
        S_ISSUE: state <= S_WAIT;
        S_WAIT:  if (eng_done_i) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (start_acc) begin
        done_r <= 1'b0;
        err_r  <= 1'b0;
      end else if (state == S_WAIT && eng_done_i) begin
        done_r <= 1'b1;
        err_r  <= eng_err_i;
      end
      // Events from the launching cycle itself survive the clear.
      ovf_r <= (ovf_r & ~start_acc) | st_evt.ovf | ld_evt.ovf;
      unf_r <= (unf_r & ~start_acc) | st_evt.unf | ld_evt.unf;
    end
  end
endmodule

// File: tb/tb_sd_ctrl_regs.sv
// Self-checking bench for sd_ctrl_regs: directed table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_sd_ctrl_regs;
  localparam int DEPTH = 16;

  logic        pclk = 1'b0;
  logic        preset;
  logic [15:0] data_i, ld_data_i;
  logic        st_buf_enq, addr_reg_ld, ctrl_reg_ld, ld_buf_deq;
  logic        st_deq_i, ld_enq_i, eng_done_i, eng_err_i;
  logic [15:0] ld_buf_data_o, status_reg_data_o, st_data_o, addr_o;
  logic        st_empty_o, ld_full_o, cmd_start_o;
  logic [7:0]  cmd_o;

  always #5 pclk = ~pclk;

  sd_ctrl_regs #(.DEPTH(DEPTH)) dut (
    .pclk(pclk), .preset(preset), .data_i(data_i),
    .st_buf_enq(st_buf_enq), .addr_reg_ld(addr_reg_ld), .ctrl_reg_ld(ctrl_reg_ld),
    .ld_buf_deq(ld_buf_deq), .ld_buf_data_o(ld_buf_data_o),
    .status_reg_data_o(status_reg_data_o), .st_deq_i(st_deq_i),
    .st_data_o(st_data_o), .st_empty_o(st_empty_o), .ld_enq_i(ld_enq_i),
    .ld_data_i(ld_data_i), .ld_full_o(ld_full_o), .cmd_start_o(cmd_start_o),
    .cmd_o(cmd_o), .addr_o(addr_o), .eng_done_i(eng_done_i), .eng_err_i(eng_err_i)
  );

  typedef struct packed {
    logic st_enq, st_deq, ld_enq, ld_deq, addr_ld, ctrl_ld, done, err;
    logic [15:0] d, ld_d;
  } in_t;

  typedef struct {
    in_t         in;
    logic [15:0] status;
    logic        start;
    logic [7:0]  cmd;
    logic [15:0] addr;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model
  logic [15:0] st_q[$], ld_q[$];
  int          m_phase;  // 0 idle, 1 launching, 2 waiting for engine
  bit          m_done, m_err, m_ovf, m_unf;
  logic [7:0]  m_cmd;
  logic [15:0] m_addr;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    st_q.delete(); ld_q.delete();
    m_phase = 0; m_done = 0; m_err = 0; m_ovf = 0; m_unf = 0;
    m_cmd = '0; m_addr = '0;
  endfunction

  function automatic void model_step(input in_t x);
    bit start_acc = x.ctrl_ld && x.d[15] && m_phase == 0;
    bit ovf_s = 0, unf_s = 0;
    if (x.ctrl_ld && x.d[14]) st_q.delete();
    else begin
      int n = st_q.size();
      if (x.st_deq && n > 0) void'(st_q.pop_front());
      if (x.st_enq) begin
        if (n < DEPTH || x.st_deq) st_q.push_back(x.d);
        else ovf_s = 1;
      end
      if (x.st_deq && n == 0 && !x.st_enq) unf_s = 1;
    end
    if (x.ctrl_ld && x.d[13]) ld_q.delete();
    else begin
      int n = ld_q.size();
      if (x.ld_deq && n > 0) void'(ld_q.pop_front());
      if (x.ld_enq) begin
        if (n < DEPTH || x.ld_deq) ld_q.push_back(x.ld_d);
        else ovf_s = 1;
      end
      if (x.ld_deq && n == 0 && !x.ld_enq) unf_s = 1;
    end
    m_ovf = (m_ovf && !start_acc) || ovf_s;
    m_unf = (m_unf && !start_acc) || unf_s;
    if (x.addr_ld) m_addr = x.d;
    if (start_acc) begin
      m_done = 0; m_err = 0; m_cmd = x.d[7:0];
    end else if (m_phase == 2 && x.done) begin
      m_done = 1; m_err = x.err;
    end
    case (m_phase)
      0: if (start_acc) m_phase = 1;
      1: m_phase = 2;
      default: if (x.done) m_phase = 0;
    endcase
  endfunction

  function automatic logic [15:0] exp_status();
    logic [15:0] s = '0;
    int nl = ld_q.size();
    int ns = st_q.size();
    s[0] = m_phase != 0;
    s[1] = m_done;
    s[2] = m_err;
    s[3] = ns == DEPTH;
    s[4] = ns == 0;
    s[5] = nl == DEPTH;
    s[6] = nl == 0;
    s[7] = m_ovf;
    s[8] = m_unf;
    s[13:9] = 5'(nl);
    return s;
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ":status"}, status_reg_data_o, exp_status());
    check({tag, ":cmd_start"}, 16'(cmd_start_o), 16'(m_phase == 1));
    check({tag, ":cmd"}, 16'(cmd_o), 16'(m_cmd));
    check({tag, ":addr"}, addr_o, m_addr);
    check({tag, ":ld_data"}, ld_buf_data_o, ld_q.size() == 0 ? 16'h0000 : ld_q[0]);
    if (st_q.size() != 0) check({tag, ":st_data"}, st_data_o, st_q[0]);
  endtask

  task automatic drive(input in_t x);
    st_buf_enq = x.st_enq; st_deq_i = x.st_deq; ld_enq_i = x.ld_enq;
    ld_buf_deq = x.ld_deq; addr_reg_ld = x.addr_ld; ctrl_reg_ld = x.ctrl_ld;
    eng_done_i = x.done; eng_err_i = x.err; data_i = x.d; ld_data_i = x.ld_d;
  endtask

  task automatic cyc(input in_t x, input string tag);
    drive(x);
    @(posedge pclk);
    model_step(x);
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset();
    drive('0);
    preset = 1'b0;
    model_reset();
    repeat (2) @(posedge pclk);
    #1;
    check("rst:status", status_reg_data_o, 16'h0050);
    check("rst:cmd_start", 16'(cmd_start_o), 16'h0);
    check("rst:ld_data", ld_buf_data_o, 16'h0000);
    check("rst:cmd", 16'(cmd_o), 16'h0);
    check("rst:addr", addr_o, 16'h0);
    preset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[6];
    in_t  x;

    do_reset();

    // command launch / ignore / completion
    tbl[0].in = '0; tbl[0].in.addr_ld = 1; tbl[0].in.d = 16'h0200;
    tbl[0].status = 16'h0050; tbl[0].start = 0; tbl[0].cmd = 8'h00; tbl[0].addr = 16'h0200;
    tbl[1].in = '0; tbl[1].in.ctrl_ld = 1; tbl[1].in.d = 16'h8011;
    tbl[1].status = 16'h0051; tbl[1].start = 1; tbl[1].cmd = 8'h11; tbl[1].addr = 16'h0200;
    tbl[2].in = '0;
    tbl[2].status = 16'h0051; tbl[2].start = 0; tbl[2].cmd = 8'h11; tbl[2].addr = 16'h0200;
    tbl[3].in = '0; tbl[3].in.ctrl_ld = 1; tbl[3].in.d = 16'h8022;
    tbl[3].status = 16'h0051; tbl[3].start = 0; tbl[3].cmd = 8'h11; tbl[3].addr = 16'h0200;
    tbl[4].in = '0; tbl[4].in.done = 1; tbl[4].in.err = 1;
    tbl[4].status = 16'h0056; tbl[4].start = 0; tbl[4].cmd = 8'h11; tbl[4].addr = 16'h0200;
    tbl[5].in = '0; tbl[5].in.done = 1;
    tbl[5].status = 16'h0056; tbl[5].start = 0; tbl[5].cmd = 8'h11; tbl[5].addr = 16'h0200;
    for (int i = 0; i < 6; i++) begin
      cyc(tbl[i].in, $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d:status_k", i), status_reg_data_o, tbl[i].status);
      check($sformatf("tbl%0d:start_k", i), 16'(cmd_start_o), 16'(tbl[i].start));
      check($sformatf("tbl%0d:cmd_k", i), 16'(cmd_o), 16'(tbl[i].cmd));
      check($sformatf("tbl%0d:addr_k", i), addr_o, tbl[i].addr);
    end

    // ST fill past full, then drain in order
    for (int i = 0; i < 16; i++) begin
      x = '0; x.st_enq = 1; x.d = 16'h1000 + 16'(i);
      cyc(x, "st_fill");
    end
    check("st_full", 16'(status_reg_data_o[3]), 16'h1);
    x = '0; x.st_enq = 1; x.d = 16'hBEEF;
    cyc(x, "st_ovf");
    check("st_ovf_flag", 16'(status_reg_data_o[7]), 16'h1);
    for (int i = 0; i < 16; i++) begin
      check("st_order", st_data_o, 16'h1000 + 16'(i));
      x = '0; x.st_deq = 1;
      cyc(x, "st_drain");
    end
    check("st_empty_after", 16'(st_empty_o), 16'h1);

    // LD underflow, then simultaneous push/pop
    x = '0; x.ld_deq = 1;
    cyc(x, "ld_unf");
    check("ld_unf_flag", 16'(status_reg_data_o[8]), 16'h1);
    check("ld_unf_cnt", 16'(status_reg_data_o[13:9]), 16'h0);
    for (int i = 0; i < 3; i++) begin
      x = '0; x.ld_enq = 1; x.ld_d = 16'h00A0 + 16'(i);
      cyc(x, "ld_push");
    end
    x = '0; x.ld_enq = 1; x.ld_deq = 1; x.ld_d = 16'h00A3;
    cyc(x, "ld_both");
    check("ld_both_cnt", 16'(status_reg_data_o[13:9]), 16'h3);
    for (int i = 1; i < 4; i++) begin
      check("ld_order", ld_buf_data_o, 16'h00A0 + 16'(i));
      x = '0; x.ld_deq = 1;
      cyc(x, "ld_pop");
    end
    check("ld_empty_data", ld_buf_data_o, 16'h0000);

    // flush both buffers, then reset during WAIT
    for (int i = 0; i < 5; i++) begin
      x = '0; x.st_enq = 1; x.ld_enq = 1; x.d = 16'h2000 + 16'(i); x.ld_d = 16'h3000 + 16'(i);
      cyc(x, "fill5");
    end
    check("fill5_ldcnt", 16'(status_reg_data_o[13:9]), 16'h5);
    x = '0; x.ctrl_ld = 1; x.d = 16'h6000;
    cyc(x, "flush");
    check("flush_st_empty", 16'(status_reg_data_o[4]), 16'h1);
    check("flush_ld_empty", 16'(status_reg_data_o[6]), 16'h1);
    x = '0; x.ctrl_ld = 1; x.d = 16'h8005;
    cyc(x, "launch");
    x = '0; x.st_enq = 1; x.d = 16'h4444;
    cyc(x, "wait");
    check("wait_busy", 16'(status_reg_data_o[0]), 16'h1);
    #3 preset = 1'b0;
    model_reset();
    #1;
    check("midrst:status", status_reg_data_o, 16'h0050);
    check("midrst:cmd_start", 16'(cmd_start_o), 16'h0);
    check("midrst:cmd", 16'(cmd_o), 16'h0);
    drive('0);
    #1 preset = 1'b1;
    cyc('0, "post_rst");

    // randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      x = '0;
      x.st_enq  = ($urandom_range(99) < 50);
      x.st_deq  = ($urandom_range(99) < 40);
      x.ld_enq  = ($urandom_range(99) < 50);
      x.ld_deq  = ($urandom_range(99) < 40);
      x.addr_ld = ($urandom_range(99) < 10);
      x.ctrl_ld = ($urandom_range(99) < 5);
      x.done    = ($urandom_range(99) < 10);
      x.err     = ($urandom_range(1) == 1);
      x.d       = 16'($urandom);
      x.ld_d    = 16'($urandom);
      cyc(x, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
